inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: assembles 16-bit instructions from bytes
//  entered on the board switches and writes them sequentially into instruction memory, while
//  the processor core only reads it. Sits between the switch/button inputs and the
//  instruction-memory write port, holding the processor stalled while a program is loaded.
// PARAMETERS
//  INST_WIDTH  16  instruction word width; must equal 2*BYTE_WIDTH
//  BYTE_WIDTH  8   width of byte_in (switch bank)
//  ADDR_WIDTH  8   instruction-memory address width; capacity = 2**ADDR_WIDTH words
// PORTS
//  clk          in   1             system clock, all state on rising edge
//  rst          in   1             asynchronous active-high reset
//  load_en      in   1             async level (switch): 1 = loader mode
//  byte_in      in   BYTE_WIDTH    byte from switches, quasi-static
//  byte_strobe  in   1             async (button): rising edge = byte_in is valid
//  im_we        out  1             instruction-memory write enable, 1-cycle pulse
//  im_addr      out  ADDR_WIDTH    write address
//  im_wdata     out  INST_WIDTH    write data
//  proc_stall   out  1             hold processor PC/writes while 1
//  load_done    out  1             sticky: a load session has ended
//  mem_full     out  1             all 2**ADDR_WIDTH words written this session
//  words_loaded out  ADDR_WIDTH+1  words written this session
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; all outputs 0; hi-byte register 0; sync flops 0.
//  - load_en and byte_strobe each pass a 2-flop synchronizer; strobe edge pulse =
//    sync_q & ~prev_q (1 cycle). Edge pulse appears 2 clocks after strobe first sampled high;
//    byte_in sampled on the edge-pulse cycle and must be stable for 3 clocks after strobe rise.
//    Holding strobe high yields exactly one pulse.
//  - FSM states: IDLE, LOAD_HI, LOAD_LO, WRITE.
//    IDLE:    load_en_s rises -> LOAD_HI; clear words_loaded, im_addr, mem_full, load_done.
//    LOAD_HI: edge -> hi_byte<=byte_in, go LOAD_LO.
//    LOAD_LO: edge -> im_wdata<={hi_byte,byte_in}, go WRITE.
//    WRITE:   im_we=1 for exactly this cycle at current im_addr; next cycle im_addr+1
//             (wraps to 0), words_loaded+1; go LOAD_HI, or IDLE if load_en_s is 0.
//  - Byte order: first byte = instruction[15:8], second = [7:0].
//  - proc_stall = 1 in LOAD_HI, LOAD_LO, WRITE; 0 in IDLE. Registered, no glitches.
//  - load_en_s falls in LOAD_HI/LOAD_LO: go IDLE, pending high byte discarded, no write,
//    load_done<=1. Falls during WRITE: write completes, then IDLE with load_done<=1.
//  - Edge and load_en_s fall in same cycle: fall wins, byte ignored.
//  - Full: when words_loaded reaches 2**ADDR_WIDTH, mem_full<=1; further edges ignored
//    (stay LOAD_HI, no im_we) until load_en_s falls. im_addr wraps to 0 but is never written.
//  - im_wdata and im_addr hold their last values outside WRITE; only im_we qualifies them.
//  - Re-entry with load_en rising again restarts at address 0 (program overwrite).
//  - Reset during WRITE: im_we drops asynchronously, memory write must not be counted.
// TESTING
//  1 reset: rst=1 with random inputs -> all outputs 0, state IDLE; release -> still 0.
//  2 load_en=1; bytes 12,34,AB,CD,00,FF; load_en=0 -> im_we at addr 0,1,2 with 1234,ABCD,
//    00FF; words_loaded=3; proc_stall 1 during load, 0 after; load_done=1.
//  3 odd byte: load_en=1, bytes 12,34,56; load_en=0 -> one write (1234@0), 56 discarded,
//    words_loaded=1, load_done=1.
//  4 ADDR_WIDTH=2: load 5 words -> writes to addr 0..3 only, mem_full=1, words_loaded=4,
//    no im_we for 5th word.
//  5 strobe held high 50 cycles with byte_in=5A -> exactly one byte captured; bounce-free edge
//    count equals byte count; strobe pulse width 3 clocks still captured.
//  6 rst asserted mid-session in LOAD_LO and on the WRITE cycle -> outputs 0 immediately,
//    next load_en rise starts at addr 0 with load_done=0.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: assembles 16-bit words from switch bytes (high byte first)
// and writes them sequentially into instruction memory, stalling the core while loading.
module inst_mem_loader #(
  parameter int unsigned INST_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  input  logic                  byte_strobe,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [INST_WIDTH-1:0] im_wdata,
  output logic                  proc_stall,
  output logic                  load_done,
  output logic                  mem_full,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [1:0] {StIdle, StLoadHi, StLoadLo, StWrite} state_e;

  localparam logic [ADDR_WIDTH:0] Capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic                  load_en_meta_q, load_en_s_q;
  logic                  strobe_meta_q, strobe_sync_q, strobe_prev_q;
  logic                  strobe_edge;
  logic [BYTE_WIDTH-1:0] hi_byte_q, hi_byte_d;
  logic [INST_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic                  stall_q, stall_d;

  // A held strobe produces a single pulse on its synchronized rising edge.
  assign strobe_edge = strobe_sync_q & ~strobe_prev_q;

  always_comb begin
    state_d   = state_q;
    hi_byte_d = hi_byte_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    count_d   = count_q;
    full_d    = full_q;
    done_d    = done_q;
    case (state_q)
      StIdle: begin
        if (load_en_s_q) begin
          state_d = StLoadHi;
          addr_d  = '0;
          count_d = '0;
          full_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      StLoadHi: begin
        // A falling load_en outranks a strobe edge in the same cycle.
        if (!load_en_s_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (strobe_edge && !full_q) begin
          hi_byte_d = byte_in;
          state_d   = StLoadLo;
        end
      end
      StLoadLo: begin
        if (!load_en_s_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (strobe_edge) begin
          wdata_d = {hi_byte_q, byte_in};
          state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        full_d  = (count_d == Capacity);
        if (load_en_s_q) begin
          state_d = StLoadHi;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    we_d    = (state_d == StWrite);
    stall_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      load_en_meta_q <= 1'b0;
      load_en_s_q    <= 1'b0;
      strobe_meta_q  <= 1'b0;
      strobe_sync_q  <= 1'b0;
      strobe_prev_q  <= 1'b0;
      hi_byte_q      <= '0;
      wdata_q        <= '0;
      addr_q         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      done_q         <= 1'b0;
      we_q           <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_en_meta_q <= load_en;
      load_en_s_q    <= load_en_meta_q;
      strobe_meta_q  <= byte_strobe;
      strobe_sync_q  <= strobe_meta_q;
      strobe_prev_q  <= strobe_sync_q;
      hi_byte_q      <= hi_byte_d;
      wdata_q        <= wdata_d;
      addr_q         <= addr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      done_q         <= done_d;
      we_q           <= we_d;
      stall_q        <= stall_d;
    end
  end

  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign proc_stall   = stall_q;
  assign load_done    = done_q;
  assign mem_full     = full_q;
  assign words_loaded = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: a 256-word and a 4-word instance share stimulus; writes are
// captured and compared against literal vectors and a word-list model.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_strobe = 1'b0;

  logic        im_we, proc_stall, load_done, mem_full;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic [8:0]  words_loaded;

  logic        im_we2, proc_stall2, load_done2, mem_full2;
  logic [1:0]  im_addr2;
  logic [15:0] im_wdata2;
  logic [2:0]  words_loaded2;

  inst_mem_loader #(.INST_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .byte_in(byte_in), .byte_strobe(byte_strobe),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .proc_stall(proc_stall),
    .load_done(load_done), .mem_full(mem_full), .words_loaded(words_loaded)
  );

  inst_mem_loader #(.INST_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .load_en(load_en), .byte_in(byte_in), .byte_strobe(byte_strobe),
    .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2), .proc_stall(proc_stall2),
    .load_done(load_done2), .mem_full(mem_full2), .words_loaded(words_loaded2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] wq_a[$];
  logic [15:0] wq_d[$];
  logic [31:0] wq2_a[$];
  logic [15:0] wq2_d[$];
  logic [7:0]  sess[$];
  logic [15:0] exp_w[$];

  always @(negedge clk) begin
    if (im_we) begin
      wq_a.push_back(32'(im_addr));
      wq_d.push_back(im_wdata);
    end
    if (im_we2) begin
      wq2_a.push_back(32'(im_addr2));
      wq2_d.push_back(im_wdata2);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(im_we), 0);
    check({tag, "_addr"}, 32'(im_addr), 0);
    check({tag, "_wdata"}, 32'(im_wdata), 0);
    check({tag, "_stall"}, 32'(proc_stall), 0);
    check({tag, "_done"}, 32'(load_done), 0);
    check({tag, "_full"}, 32'(mem_full), 0);
    check({tag, "_words"}, 32'(words_loaded), 0);
    check({tag, "_we2"}, 32'(im_we2), 0);
    check({tag, "_stall2"}, 32'(proc_stall2), 0);
    check({tag, "_words2"}, 32'(words_loaded2), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    byte_in = b;
    byte_strobe = 1'b1;
    repeat (hold) @(negedge clk);
    byte_strobe = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic start_session(input string tag);
    wq_a.delete(); wq_d.delete(); wq2_a.delete(); wq2_d.delete();
    @(negedge clk);
    load_en = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, "_start_stall"}, 32'(proc_stall), 1);
    check({tag, "_start_words"}, 32'(words_loaded), 0);
    check({tag, "_start_done"}, 32'(load_done), 0);
    check({tag, "_start_full2"}, 32'(mem_full2), 0);
  endtask

  task automatic end_session();
    @(negedge clk);
    load_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_session(input string tag, input int hold);
    start_session(tag);
    foreach (sess[k]) send_byte(sess[k], hold);
    end_session();
  endtask

  // nw = complete words offered this session; each instance keeps only its capacity.
  task automatic check_session(input string tag, input int nw);
    int n1, n2;
    n1 = (nw < 256) ? nw : 256;
    n2 = (nw < 4) ? nw : 4;
    check({tag, "_nwr"}, 32'(wq_a.size()), 32'(n1));
    for (int i = 0; i < n1 && i < wq_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wq_a[i], 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(wq_d[i]), 32'(exp_w[i]));
    end
    check({tag, "_nwr2"}, 32'(wq2_a.size()), 32'(n2));
    for (int i = 0; i < n2 && i < wq2_a.size(); i++) begin
      check($sformatf("%s_addr2_%0d", tag, i), wq2_a[i], 32'(i));
      check($sformatf("%s_data2_%0d", tag, i), 32'(wq2_d[i]), 32'(exp_w[i]));
    end
    check({tag, "_words"}, 32'(words_loaded), 32'(n1));
    check({tag, "_words2"}, 32'(words_loaded2), 32'(n2));
    check({tag, "_full"}, 32'(mem_full), 32'(nw >= 256));
    check({tag, "_full2"}, 32'(mem_full2), 32'(nw >= 4));
    check({tag, "_done"}, 32'(load_done), 1);
    check({tag, "_stall"}, 32'(proc_stall), 0);
    check({tag, "_we"}, 32'(im_we), 0);
  endtask

  typedef struct {
    int          nb;
    logic [95:0] bytes;
    int          hold;
    int          nw;
    logic [79:0] words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   nb;
    int   hold;
    bit   seen;

    vecs[0] = '{6,  96'h1234ABCD00FF000000000000, 4,  3, 80'h1234ABCD00FF00000000};
    vecs[1] = '{3,  96'h123456000000000000000000, 4,  1, 80'h12340000000000000000};
    vecs[2] = '{10, 96'h0102030405060708090A0000, 4,  5, 80'h0102030405060708090A};
    vecs[3] = '{2,  96'h5A3C00000000000000000000, 50, 1, 80'h5A3C0000000000000000};
    vecs[4] = '{2,  96'hC39600000000000000000000, 3,  1, 80'hC3960000000000000000};

    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      load_en = 1'($urandom);
      byte_in = 8'($urandom);
      byte_strobe = 1'($urandom);
      @(negedge clk);
      check_all_zero("rst");
    end
    load_en = 1'b0;
    byte_strobe = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("rst_rel");

    // Literal vectors.
    for (int v = 0; v < 5; v++) begin
      sess.delete();
      exp_w.delete();
      for (int k = 0; k < vecs[v].nb; k++) sess.push_back(vecs[v].bytes[95 - 8*k -: 8]);
      for (int k = 0; k < vecs[v].nw; k++) exp_w.push_back(vecs[v].words[79 - 16*k -: 16]);
      run_session($sformatf("vec%0d", v), vecs[v].hold);
      check_session($sformatf("vec%0d", v), vecs[v].nw);
    end

    // Reset while waiting for the low byte.
    start_session("r6a");
    send_byte(8'h12, 4);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_lo");
    load_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset on the write cycle: write must not be counted.
    start_session("r6b");
    send_byte(8'h77, 4);
    @(negedge clk);
    byte_in = 8'h88;
    byte_strobe = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (im_we) seen = 1'b1;
    end
    check("r6b_write_seen", 32'(seen), 1);
    check("r6b_write_addr", 32'(im_addr), 0);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_wr");
    load_en = 1'b0;
    byte_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    sess.delete();
    exp_w.delete();
    sess.push_back(8'hAB);
    sess.push_back(8'hCD);
    exp_w.push_back(16'hABCD);
    run_session("r6c", 4);
    check_session("r6c", 1);

    // Random sessions against the word-list model.
    for (int s = 0; s < 8; s++) begin
      nb = $urandom_range(0, 12);
      hold = $urandom_range(3, 6);
      sess.delete();
      exp_w.delete();
      for (int k = 0; k < nb; k++) sess.push_back(8'($urandom));
      for (int k = 0; k + 1 < nb; k += 2) exp_w.push_back({sess[k], sess[k+1]});
      run_session($sformatf("rnd%0d", s), hold);
      check_session($sformatf("rnd%0d", s), nb / 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
